// File: rtl/axi_rw_arbiter_n.sv
// axi_rw_arbiter_n: N-channel round-robin arbiter onto a single read/write bus.
// One transaction is in flight at a time: grant -> address phase -> wait for
// the response. Optional watchdog on the wait states is enabled by defining
// ARB_TIMEOUT_EN; without it err is tied low and the wait is unbounded.

// Per-channel return path: only the granted channel sees readies/responses.
module axi_rw_arbiter_n_lane (
    input  logic i_sel,
    input  logic i_rd_addr,
    input  logic i_wr_addr,
    input  logic i_rd_wait,
    input  logic i_wr_wait,
    input  logic i_d_read_addr_ready,
    input  logic i_d_write_addr_ready,
    input  logic i_d_read_data_valid,
    input  logic i_d_write_resp_valid,
    output logic o_read_addr_ready,
    output logic o_write_addr_ready,
    output logic o_read_data_valid,
    output logic o_write_resp_valid
);
    assign o_read_addr_ready  = i_sel & i_rd_addr & i_d_read_addr_ready;
    assign o_write_addr_ready = i_sel & i_wr_addr & i_d_write_addr_ready;
    assign o_read_data_valid  = i_sel & i_rd_wait & i_d_read_data_valid;
    assign o_write_resp_valid = i_sel & i_wr_wait & i_d_write_resp_valid;
endmodule

module axi_rw_arbiter_n #(
    parameter int NUM_CH     = 2,
    parameter int WIDTH      = 32,
    parameter int TIMEOUT    = 255,
    parameter int ADDR_WIDTH = 32,
    localparam int WORD_SIZE = WIDTH / 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    i_c_read_addr,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    i_c_write_addr,
    input  logic [NUM_CH-1:0]                    i_c_read_addr_valid,
    input  logic [NUM_CH-1:0]                    i_c_write_addr_valid,
    input  logic [NUM_CH-1:0][WIDTH-1:0]         i_c_write_data,
    input  logic [NUM_CH-1:0][WORD_SIZE-1:0]     i_c_strobe,
    input  logic [NUM_CH-1:0][1:0]               i_c_size,
    input  logic [NUM_CH-1:0]                    i_c_lu,
    output logic [NUM_CH-1:0]                    o_c_read_addr_ready,
    output logic [NUM_CH-1:0]                    o_c_write_addr_ready,
    output logic [NUM_CH-1:0]                    o_c_read_data_valid,
    output logic [NUM_CH-1:0]                    o_c_write_resp_valid,
    output logic [WIDTH-1:0]                     o_c_read_data,
    output logic [ADDR_WIDTH-1:0]                o_d_read_addr,
    output logic                                 o_d_read_addr_valid,
    input  logic                                 i_d_read_addr_ready,
    input  logic [WIDTH-1:0]                     i_d_read_data,
    input  logic                                 i_d_read_data_valid,
    output logic [ADDR_WIDTH-1:0]                o_d_write_addr,
    output logic                                 o_d_write_addr_valid,
    input  logic                                 i_d_write_addr_ready,
    output logic [WIDTH-1:0]                     o_d_write_data,
    output logic [WORD_SIZE-1:0]                 o_d_strobe,
    output logic [1:0]                           o_d_size,
    output logic                                 o_d_lu,
    input  logic                                 i_d_write_resp_valid,
    output logic [NUM_CH-1:0]                    o_err
);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, WR_ADDR, WR_WAIT} state_t;

    state_t        r_state, w_next;
    logic [GW-1:0] r_grant, r_ptr, w_sel, w_grant_inc;
    logic          w_found, w_rsp_done, w_timeout, w_wd_hit;
    logic          w_rd_addr, w_wr_addr, w_rd_wait, w_wr_wait;
    logic [NUM_CH-1:0] w_req;

    assign w_req       = i_c_read_addr_valid | i_c_write_addr_valid;
    assign w_rd_addr   = (r_state == RD_ADDR);
    assign w_wr_addr   = (r_state == WR_ADDR);
    assign w_rd_wait   = (r_state == RD_WAIT);
    assign w_wr_wait   = (r_state == WR_WAIT);
    assign w_grant_inc = (r_grant == GW'(NUM_CH - 1)) ? '0 : r_grant + GW'(1);

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && w_req[(int'(r_ptr) + k) % NUM_CH]) begin
                w_found = 1'b1;
                w_sel   = GW'((int'(r_ptr) + k) % NUM_CH);
            end
        end
    end

    // Next-state: reads win when the chosen channel asks for both.
    always_comb begin
        w_next     = r_state;
        w_rsp_done = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE:    if (w_found) w_next = i_c_read_addr_valid[w_sel] ? RD_ADDR : WR_ADDR;
            RD_ADDR: if (!i_c_read_addr_valid[r_grant]) w_next = IDLE;
                     else if (i_d_read_addr_ready)      w_next = RD_WAIT;
            WR_ADDR: if (!i_c_write_addr_valid[r_grant]) w_next = IDLE;
                     else if (i_d_write_addr_ready)      w_next = WR_WAIT;
            RD_WAIT: if (i_d_read_data_valid) begin
                         w_next = IDLE; w_rsp_done = 1'b1;
                     end else if (w_wd_hit) begin
                         w_next = IDLE; w_timeout = 1'b1;
                     end
            WR_WAIT: if (i_d_write_resp_valid) begin
                         w_next = IDLE; w_rsp_done = 1'b1;
                     end else if (w_wd_hit) begin
                         w_next = IDLE; w_timeout = 1'b1;
                     end
            default: w_next = IDLE;
        endcase
    end

    // State, grant and fairness pointer; an abandoned request leaves ptr alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_found) r_grant <= w_sel;
            if (w_rsp_done || w_timeout)    r_ptr   <= w_grant_inc;
        end
    end

    // Device-side mux: only the granted channel's fields, only in its address phase.
    always_comb begin
        o_d_read_addr        = '0;
        o_d_read_addr_valid  = 1'b0;
        o_d_write_addr       = '0;
        o_d_write_addr_valid = 1'b0;
        o_d_write_data       = '0;
        o_d_strobe           = '0;
        o_d_size             = '0;
        o_d_lu               = 1'b0;
        if (w_rd_addr) begin
            o_d_read_addr       = i_c_read_addr[r_grant];
            o_d_read_addr_valid = i_c_read_addr_valid[r_grant];
        end
        if (w_wr_addr) begin
            o_d_write_addr       = i_c_write_addr[r_grant];
            o_d_write_addr_valid = i_c_write_addr_valid[r_grant];
            o_d_write_data       = i_c_write_data[r_grant];
            o_d_strobe           = i_c_strobe[r_grant];
            o_d_size             = i_c_size[r_grant];
            o_d_lu               = i_c_lu[r_grant];
        end
    end

    assign o_c_read_data = i_d_read_data;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        axi_rw_arbiter_n_lane u_lane (
            .i_sel                (r_grant == GW'(g)),
            .i_rd_addr            (w_rd_addr),
            .i_wr_addr            (w_wr_addr),
            .i_rd_wait            (w_rd_wait),
            .i_wr_wait            (w_wr_wait),
            .i_d_read_addr_ready  (i_d_read_addr_ready),
            .i_d_write_addr_ready (i_d_write_addr_ready),
            .i_d_read_data_valid  (i_d_read_data_valid),
            .i_d_write_resp_valid (i_d_write_resp_valid),
            .o_read_addr_ready    (o_c_read_addr_ready[g]),
            .o_write_addr_ready   (o_c_write_addr_ready[g]),
            .o_read_data_valid    (o_c_read_data_valid[g]),
            .o_write_resp_valid   (o_c_write_resp_valid[g])
        );
    end

`ifdef ARB_TIMEOUT_EN
    localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [WDW-1:0] r_wdog;

    // Wait-cycle counter: zero on the first wait cycle, fires on the TIMEOUT-th.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       r_wdog <= '0;
        else if (w_rd_wait || w_wr_wait) r_wdog <= r_wdog + WDW'(1);
        else                           r_wdog <= '0;
    end

    assign w_wd_hit = (r_wdog == WDW'(TIMEOUT - 1));

    // Error pulse lands on the channel that was waiting when the watchdog fired.
    always_comb begin
        o_err = '0;
        if (w_timeout) o_err[r_grant] = 1'b1;
    end
`else
    assign w_wd_hit = 1'b0;
    assign o_err    = '0;
`endif

endmodule

// File: tb/tb_axi_rw_arbiter_n.sv
// Bench for axi_rw_arbiter_n (NUM_CH=2, TIMEOUT=10). A transaction-level model
// of the arbiter is checked against the DUT every cycle; directed scenarios add
// literal expectations on grant order, data and latency.
module tb_axi_rw_arbiter_n;
    localparam int N  = 2;
    localparam int W  = 32;
    localparam int AW = 32;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0][AW-1:0]  i_c_read_addr, i_c_write_addr;
    logic [N-1:0]          i_c_read_addr_valid, i_c_write_addr_valid;
    logic [N-1:0][W-1:0]   i_c_write_data;
    logic [N-1:0][W/8-1:0] i_c_strobe;
    logic [N-1:0][1:0]     i_c_size;
    logic [N-1:0]          i_c_lu;
    logic [N-1:0]          o_c_read_addr_ready, o_c_write_addr_ready;
    logic [N-1:0]          o_c_read_data_valid, o_c_write_resp_valid;
    logic [W-1:0]          o_c_read_data;
    logic [AW-1:0]         o_d_read_addr, o_d_write_addr;
    logic                  o_d_read_addr_valid, o_d_write_addr_valid;
    logic                  i_d_read_addr_ready, i_d_write_addr_ready;
    logic [W-1:0]          i_d_read_data, o_d_write_data;
    logic                  i_d_read_data_valid, i_d_write_resp_valid;
    logic [W/8-1:0]        o_d_strobe;
    logic [1:0]            o_d_size;
    logic                  o_d_lu;
    logic [N-1:0]          o_err;

    axi_rw_arbiter_n #(.NUM_CH(N), .WIDTH(W), .TIMEOUT(TO), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_c_read_addr(i_c_read_addr), .i_c_write_addr(i_c_write_addr),
        .i_c_read_addr_valid(i_c_read_addr_valid), .i_c_write_addr_valid(i_c_write_addr_valid),
        .i_c_write_data(i_c_write_data), .i_c_strobe(i_c_strobe), .i_c_size(i_c_size), .i_c_lu(i_c_lu),
        .o_c_read_addr_ready(o_c_read_addr_ready), .o_c_write_addr_ready(o_c_write_addr_ready),
        .o_c_read_data_valid(o_c_read_data_valid), .o_c_write_resp_valid(o_c_write_resp_valid),
        .o_c_read_data(o_c_read_data),
        .o_d_read_addr(o_d_read_addr), .o_d_read_addr_valid(o_d_read_addr_valid),
        .i_d_read_addr_ready(i_d_read_addr_ready), .i_d_read_data(i_d_read_data),
        .i_d_read_data_valid(i_d_read_data_valid),
        .o_d_write_addr(o_d_write_addr), .o_d_write_addr_valid(o_d_write_addr_valid),
        .i_d_write_addr_ready(i_d_write_addr_ready), .o_d_write_data(o_d_write_data),
        .o_d_strobe(o_d_strobe), .o_d_size(o_d_size), .o_d_lu(o_d_lu),
        .i_d_write_resp_valid(i_d_write_resp_valid), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int cmp_n = 0;
    int err_n = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- device model ----------------
    int          dev_wr_wait = 0;
    bit          dev_mute    = 0;
    logic [31:0] dev_rdata   = 32'h0;
    int          late_rsp_at = -1;
    int          cyc         = 0;
    int          late_fired  = 0;

    initial begin
        int  rd_seen, wr_seen;
        bit  rd_pend, wr_pend, rhs, whs;
        rd_seen = 0; wr_seen = 0; rd_pend = 0; wr_pend = 0;
        i_d_read_addr_ready  = 1'b1;
        i_d_write_addr_ready = 1'b1;
        i_d_read_data        = '0;
        i_d_read_data_valid  = 1'b0;
        i_d_write_resp_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            rhs = o_d_read_addr_valid && i_d_read_addr_ready;
            whs = o_d_write_addr_valid && i_d_write_addr_ready;
            if (o_d_write_addr_valid && !i_d_write_addr_ready) wr_seen++;
            if (o_d_read_addr_valid && !i_d_read_addr_ready) rd_seen++;
            if (whs) wr_seen = 0;
            if (rhs) rd_seen = 0;
            @(posedge clk); #1;
            if (rst) begin
                rd_pend = 0; wr_pend = 0; rd_seen = 0; wr_seen = 0;
            end else begin
                if (rhs) rd_pend = 1;
                if (whs) wr_pend = 1;
            end
            if (dev_mute) begin rd_pend = 0; wr_pend = 0; end
            i_d_read_data_valid  = 1'b0;
            i_d_write_resp_valid = 1'b0;
            if (rd_pend) begin
                i_d_read_data_valid = 1'b1; i_d_read_data = dev_rdata; rd_pend = 0;
            end
            if (wr_pend) begin
                i_d_write_resp_valid = 1'b1; wr_pend = 0;
            end
            if (late_rsp_at == cyc) begin
                i_d_read_data_valid = 1'b1; i_d_read_data = 32'hBAD0BAD0; late_fired++;
            end
            i_d_read_addr_ready  = 1'b1;
            i_d_write_addr_ready = (wr_seen >= dev_wr_wait);
        end
    end

    // ---------------- model + per-cycle compare ----------------
    int          m_owner = -1;
    bit          m_wr = 0, m_wait = 0;
    int          m_ptr = 0, m_wcnt = 0;
    int          log_q[$];
    logic [31:0] last_rdata[N];
    int          rdv_cnt[N];
    int          err_cnt[N];
    int          wr_stall = 0;

    initial begin
        logic [N-1:0] e_rar, e_war, e_rdv, e_wrv, e_err;
        logic         e_rav, e_wav, rsp, v, r;
        for (int k = 0; k < N; k++) begin rdv_cnt[k] = 0; err_cnt[k] = 0; last_rdata[k] = '0; end
        forever begin
            @(negedge clk);
            if (rst) begin m_owner = -1; m_ptr = 0; m_wait = 0; m_wcnt = 0; end
            e_rav = 0; e_wav = 0; e_rar = '0; e_war = '0; e_rdv = '0; e_wrv = '0; e_err = '0;
            if (m_owner >= 0) begin
                if (!m_wait && !m_wr) begin
                    e_rav = i_c_read_addr_valid[m_owner];
                    e_rar[m_owner] = i_d_read_addr_ready;
                end else if (!m_wait && m_wr) begin
                    e_wav = i_c_write_addr_valid[m_owner];
                    e_war[m_owner] = i_d_write_addr_ready;
                end else begin
                    rsp = m_wr ? i_d_write_resp_valid : i_d_read_data_valid;
                    if (m_wr) e_wrv[m_owner] = rsp; else e_rdv[m_owner] = rsp;
`ifdef ARB_TIMEOUT_EN
                    if (!rsp && m_wcnt + 1 == TO) e_err[m_owner] = 1'b1;
`endif
                end
            end
            chk("d_read_addr_valid",  o_d_read_addr_valid,  e_rav);
            chk("d_write_addr_valid", o_d_write_addr_valid, e_wav);
            chk("c_read_addr_ready",  o_c_read_addr_ready,  e_rar);
            chk("c_write_addr_ready", o_c_write_addr_ready, e_war);
            chk("c_read_data_valid",  o_c_read_data_valid,  e_rdv);
            chk("c_write_resp_valid", o_c_write_resp_valid, e_wrv);
            chk("err",                o_err,                e_err);
            if (e_rav) chk("d_read_addr", o_d_read_addr, i_c_read_addr[m_owner]);
            if (e_wav) begin
                chk("d_write_addr", o_d_write_addr, i_c_write_addr[m_owner]);
                chk("d_write_data", o_d_write_data, i_c_write_data[m_owner]);
                chk("d_strobe",     o_d_strobe,     i_c_strobe[m_owner]);
                chk("d_size",       o_d_size,       i_c_size[m_owner]);
                chk("d_lu",         o_d_lu,         i_c_lu[m_owner]);
                if (!i_d_write_addr_ready) wr_stall++;
            end
            if (|e_rdv) chk("c_read_data", o_c_read_data, i_d_read_data);
            for (int k = 0; k < N; k++) begin
                if (o_c_read_data_valid[k]) begin
                    log_q.push_back(k * 2); last_rdata[k] = o_c_read_data; rdv_cnt[k]++;
                end
                if (o_c_write_resp_valid[k]) log_q.push_back(k * 2 + 1);
                if (o_err[k]) err_cnt[k]++;
            end
            if (!rst) begin
                if (m_owner < 0) begin
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = (m_ptr + k) % N;
                        if (m_owner < 0 && (i_c_read_addr_valid[c] || i_c_write_addr_valid[c])) begin
                            m_owner = c; m_wr = !i_c_read_addr_valid[c]; m_wait = 0;
                        end
                    end
                end else if (!m_wait) begin
                    v = m_wr ? i_c_write_addr_valid[m_owner] : i_c_read_addr_valid[m_owner];
                    r = m_wr ? i_d_write_addr_ready : i_d_read_addr_ready;
                    if (!v) m_owner = -1;
                    else if (r) begin m_wait = 1; m_wcnt = 0; end
                end else begin
                    rsp = m_wr ? i_d_write_resp_valid : i_d_read_data_valid;
                    m_wcnt++;
                    if (rsp) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
`ifdef ARB_TIMEOUT_EN
                    else if (m_wcnt == TO) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
`endif
                end
            end
        end
    end

    // ---------------- channel driver ----------------
    task automatic chan_txn(input int ch, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input int n);
        bit ok;
        for (int t = 0; t < n; t++) begin
            if (wr) begin
                i_c_write_addr[ch] = addr; i_c_write_data[ch] = data;
                i_c_strobe[ch] = 4'hF; i_c_size[ch] = 2'b10; i_c_lu[ch] = 1'b0;
                i_c_write_addr_valid[ch] = 1'b1;
            end else begin
                i_c_read_addr[ch] = addr; i_c_read_addr_valid[ch] = 1'b1;
            end
            ok = 0;
            for (int k = 0; k < 300 && !ok; k++) begin
                @(negedge clk);
                ok = wr ? o_c_write_addr_ready[ch] : o_c_read_addr_ready[ch];
            end
            chk("handshake_bound", ok, 1'b1);
            @(posedge clk); #1;
            if (wr) i_c_write_addr_valid[ch] = 1'b0; else i_c_read_addr_valid[ch] = 1'b0;
            ok = 0;
            for (int k = 0; k < 300 && !ok; k++) begin
                @(negedge clk);
                ok = wr ? o_c_write_resp_valid[ch] : o_c_read_data_valid[ch];
            end
            chk("response_bound", ok, 1'b1);
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int base, st, stall0, k;
        bit ok;
        i_c_read_addr = '0; i_c_write_addr = '0;
        i_c_read_addr_valid = '0; i_c_write_addr_valid = '0;
        i_c_write_data = '0; i_c_strobe = '0; i_c_size = '0; i_c_lu = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_err", o_err, '0);
        chk("reset_d_valids", {o_d_read_addr_valid, o_d_write_addr_valid}, 2'b00);
        @(posedge clk); #1;

        // lone read on ch0, zero-wait device
        dev_rdata = 32'hDEADBEEF;
        base = log_q.size(); st = cyc;
        chan_txn(0, 0, 32'h100, 32'h0, 1);
        chk("s1_latency", cyc - st, 3);
        chk("s1_count", log_q.size() - base, 1);
        if (log_q.size() > base) chk("s1_who", log_q[base], 0);
        chk("s1_rdata", last_rdata[0], 32'hDEADBEEF);
        chk("s1_ch0_pulses", rdv_cnt[0], 1);
        chk("s1_ch1_pulses", rdv_cnt[1], 0);
        chk("s1_ptr", m_ptr, 1);
        repeat (2) @(posedge clk); #1;

        // both channels requesting back-to-back from ptr=0
        pulse_reset();
        base = log_q.size();
        fork
            chan_txn(0, 0, 32'h110, 32'h0, 2);
            chan_txn(1, 0, 32'h210, 32'h0, 2);
        join
        chk("s2_count", log_q.size() - base, 4);
        if (log_q.size() >= base + 4) begin
            chk("s2_g0", log_q[base],     0);
            chk("s2_g1", log_q[base + 1], 2);
            chk("s2_g2", log_q[base + 2], 0);
            chk("s2_g3", log_q[base + 3], 2);
        end
        repeat (2) @(posedge clk); #1;

        // ch1 write stalled 5 cycles by the device
        dev_wr_wait = 5;
        base = log_q.size(); stall0 = wr_stall;
        chan_txn(1, 1, 32'h200, 32'h12345678, 1);
        dev_wr_wait = 0;
        chk("s3_stall", wr_stall - stall0, 5);
        chk("s3_count", log_q.size() - base, 1);
        if (log_q.size() > base) chk("s3_who", log_q[base], 3);
        repeat (2) @(posedge clk); #1;

        // ch0 raises read and write together: read first
        base = log_q.size();
        fork
            chan_txn(0, 0, 32'h300, 32'h0, 1);
            chan_txn(0, 1, 32'h304, 32'hCAFEF00D, 1);
        join
        chk("s4_count", log_q.size() - base, 2);
        if (log_q.size() >= base + 2) begin
            chk("s4_first",  log_q[base],     0);
            chk("s4_second", log_q[base + 1], 1);
        end
        repeat (2) @(posedge clk); #1;

        // reset while waiting for read data; late response must vanish
        dev_mute = 1;
        i_c_read_addr[0] = 32'h400; i_c_read_addr_valid[0] = 1'b1;
        ok = 0;
        for (int j = 0; j < 50 && !ok; j++) begin @(negedge clk); ok = o_c_read_addr_ready[0]; end
        chk("s5_handshake", ok, 1'b1);
        @(posedge clk); #1;
        i_c_read_addr_valid[0] = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        late_rsp_at = cyc + 2;
        base = log_q.size();
        repeat (5) @(posedge clk); #1;
        chk("s5_late_sent", late_fired, 1);
        chk("s5_no_resp", log_q.size() - base, 0);
        chk("s5_ptr", m_ptr, 0);
        dev_mute = 0;
        dev_rdata = 32'h0BADF00D;
        chan_txn(1, 0, 32'h410, 32'h0, 1);
        chk("s5_after", last_rdata[1], 32'h0BADF00D);
        repeat (2) @(posedge clk); #1;

`ifdef ARB_TIMEOUT_EN
        // silent device: ch0 times out after 10 wait cycles, ch1 served next
        pulse_reset();
        dev_mute = 1;
        base = log_q.size();
        fork
            begin
                i_c_read_addr[0] = 32'h500; i_c_read_addr_valid[0] = 1'b1;
                ok = 0;
                for (int j = 0; j < 50 && !ok; j++) begin @(negedge clk); ok = o_c_read_addr_ready[0]; end
                chk("s6_handshake", ok, 1'b1);
                @(posedge clk); #1;
                i_c_read_addr_valid[0] = 1'b0;
                k = 0; ok = 0;
                while (k < 40 && !ok) begin @(negedge clk); k++; ok = o_err[0]; end
                chk("s6_err_seen", ok, 1'b1);
                chk("s6_err_cycle", k, TO);
                dev_mute = 0;
            end
            chan_txn(1, 0, 32'h600, 32'h0, 1);
        join
        chk("s6_err_ch0", err_cnt[0], 1);
        chk("s6_err_ch1", err_cnt[1], 0);
        chk("s6_count", log_q.size() - base, 1);
        if (log_q.size() > base) chk("s6_next", log_q[base], 2);
        repeat (2) @(posedge clk); #1;
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
